// File: rtl/axi_mem_pkg.sv
// Shared encodings and FSM state types for the AXI memory responder.
package axi_mem_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_e;
  typedef enum logic [0:0] {R_IDLE, R_DATA} r_state_e;

  // Only FIXED and INCR touch the RAM; WRAP and the reserved code answer SLVERR.
  function automatic logic burst_supported(input logic [1:0] burst);
    return (burst == BURST_FIXED) || (burst == BURST_INCR);
  endfunction

endpackage

// File: rtl/axi_mem_responder_if.sv
// AXI4 AW/W/B/AR/R bundle between the bridge user port (master) and the responder (slave).
interface axi_mem_responder_if #(
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned ID_WIDTH   = 4
);

  logic [ID_WIDTH-1:0]     awid;
  logic [ADDR_WIDTH-1:0]   awaddr;
  logic [7:0]              awlen;
  logic [2:0]              awsize;
  logic [1:0]              awburst;
  logic                    awvalid;
  logic                    awready;

  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH/8-1:0] wstrb;
  logic                    wlast;
  logic                    wvalid;
  logic                    wready;

  logic [ID_WIDTH-1:0]     bid;
  logic [1:0]              bresp;
  logic                    bvalid;
  logic                    bready;

  logic [ID_WIDTH-1:0]     arid;
  logic [ADDR_WIDTH-1:0]   araddr;
  logic [7:0]              arlen;
  logic [2:0]              arsize;
  logic [1:0]              arburst;
  logic                    arvalid;
  logic                    arready;

  logic [ID_WIDTH-1:0]     rid;
  logic [DATA_WIDTH-1:0]   rdata;
  logic [1:0]              rresp;
  logic                    rlast;
  logic                    rvalid;
  logic                    rready;

  modport master (
    output awid, awaddr, awlen, awsize, awburst, awvalid,
    output wdata, wstrb, wlast, wvalid,
    output bready,
    output arid, araddr, arlen, arsize, arburst, arvalid,
    output rready,
    input  awready, wready, bid, bresp, bvalid, arready, rid, rdata, rresp, rlast, rvalid
  );

  modport slave (
    input  awid, awaddr, awlen, awsize, awburst, awvalid,
    input  wdata, wstrb, wlast, wvalid,
    input  bready,
    input  arid, araddr, arlen, arsize, arburst, arvalid,
    input  rready,
    output awready, wready, bid, bresp, bvalid, arready, rid, rdata, rresp, rlast, rvalid
  );

endinterface

// File: rtl/axi_mem_ram.sv
// 1W1R synchronous RAM with byte enables; a same-address read returns the pre-write word.
module axi_mem_ram #(
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned DEPTH      = 256
) (
  input  logic                     clk_i,
  input  logic                     we_i,
  input  logic [$clog2(DEPTH)-1:0] waddr_i,
  input  logic [DATA_WIDTH-1:0]    wdata_i,
  input  logic [DATA_WIDTH/8-1:0]  wstrb_i,
  input  logic                     re_i,
  input  logic [$clog2(DEPTH)-1:0] raddr_i,
  output logic [DATA_WIDTH-1:0]    rdata_o
);

  localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DATA_WIDTH-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      for (int unsigned b = 0; b < STRB_WIDTH; b++) begin
        if (wstrb_i[b]) mem[waddr_i][8*b +: 8] <= wdata_i[8*b +: 8];
      end
    end
    // Output register only moves on a read strobe, so held R beats stay stable.
    if (re_i) rdata_q <= mem[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/axi_mem_responder.sv
// AXI4 slave memory endpoint: one outstanding write and one outstanding read.
// Optional: define AXI_MEM_RESP_LAST_CHECK_EN to check wlast against awlen.
module axi_mem_responder
  import axi_mem_pkg::*;
#(
  parameter int unsigned           DATA_WIDTH = 64,
  parameter int unsigned           ADDR_WIDTH = 32,
  parameter int unsigned           ID_WIDTH   = 4,
  parameter int unsigned           DEPTH      = 256,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0
) (
  input  logic               clk_wr,
  input  logic               rst_wr,
  axi_mem_responder_if.slave axi,
  output logic               err_sticky
);

  localparam int unsigned           OFF_BITS    = $clog2(DATA_WIDTH / 8);
  localparam int unsigned           IDX_WIDTH   = $clog2(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] DEPTH_WORDS = ADDR_WIDTH'(DEPTH);

  // Full-width word index: beats past the RAM end stay out of range instead of wrapping.
  function automatic logic [ADDR_WIDTH-1:0] word_index(input logic [ADDR_WIDTH-1:0] addr);
    return (addr - BASE_ADDR) >> OFF_BITS;
  endfunction

  w_state_e              w_state_q, w_state_d;
  logic [ID_WIDTH-1:0]   wid_q, wid_d;
  logic [ADDR_WIDTH-1:0] widx_q, widx_d;
  logic [7:0]            wlen_q, wlen_d, wcnt_q, wcnt_d;
  logic [1:0]            wburst_q, wburst_d;
  logic                  werr_q, werr_d;
  logic                  w_beat_last, ram_we, aw_ready, w_ready, b_valid;

  r_state_e              r_state_q, r_state_d;
  logic [ID_WIDTH-1:0]   rid_q, rid_d;
  logic [ADDR_WIDTH-1:0] ridx_q, ridx_d, r_next_idx;
  logic [7:0]            rlen_q, rlen_d, rbeat_q, rbeat_d;
  logic [1:0]            rburst_q, rburst_d, rresp_q, rresp_d;
  logic                  rlast_q, rlast_d, rok_q, rok_d;
  logic                  r_next_ok, ram_re, ar_ready, r_valid;
  logic [DATA_WIDTH-1:0] ram_rdata;

  logic                  ready_en_q, err_sticky_q, err_now;
  logic                  unused_inputs;

  assign unused_inputs = ^{axi.awsize, axi.arsize, axi.wlast};

  always_comb begin
    w_state_d   = w_state_q;
    wid_d       = wid_q;
    widx_d      = widx_q;
    wlen_d      = wlen_q;
    wcnt_d      = wcnt_q;
    wburst_d    = wburst_q;
    werr_d      = werr_q;
    w_beat_last = (wcnt_q == wlen_q);
    ram_we      = 1'b0;
    aw_ready    = 1'b0;
    w_ready     = 1'b0;
    b_valid     = 1'b0;
    unique case (w_state_q)
      W_IDLE: begin
        aw_ready = ready_en_q;
        if (aw_ready && axi.awvalid) begin
          wid_d     = axi.awid;
          widx_d    = word_index(axi.awaddr);
          wlen_d    = axi.awlen;
          wburst_d  = axi.awburst;
          wcnt_d    = '0;
          werr_d    = 1'b0;
          w_state_d = W_DATA;
        end
      end
      W_DATA: begin
        w_ready = 1'b1;
        if (axi.wvalid) begin
          if (burst_supported(wburst_q) && (widx_q < DEPTH_WORDS)) ram_we = 1'b1;
          else werr_d = 1'b1;
          wcnt_d = wcnt_q + 8'd1;
          if (wburst_q == BURST_INCR) widx_d = widx_q + ADDR_WIDTH'(1);
`ifdef AXI_MEM_RESP_LAST_CHECK_EN
          if (axi.wlast != w_beat_last) werr_d = 1'b1;
          if (axi.wlast || w_beat_last) w_state_d = W_RESP;
`else
          if (w_beat_last) w_state_d = W_RESP;
`endif
        end
      end
      W_RESP: begin
        b_valid = 1'b1;
        if (axi.bready) w_state_d = W_IDLE;
      end
      default: w_state_d = W_IDLE;
    endcase
  end

  always_comb begin
    r_state_d  = r_state_q;
    rid_d      = rid_q;
    ridx_d     = ridx_q;
    rlen_d     = rlen_q;
    rbeat_d    = rbeat_q;
    rburst_d   = rburst_q;
    rresp_d    = rresp_q;
    rlast_d    = rlast_q;
    rok_d      = rok_q;
    r_next_idx = '0;
    r_next_ok  = 1'b0;
    ram_re     = 1'b0;
    ar_ready   = 1'b0;
    r_valid    = 1'b0;
    unique case (r_state_q)
      R_IDLE: begin
        ar_ready = ready_en_q;
        if (ar_ready && axi.arvalid) begin
          r_next_idx = word_index(axi.araddr);
          r_next_ok  = burst_supported(axi.arburst) && (r_next_idx < DEPTH_WORDS);
          ram_re     = r_next_ok;
          ridx_d     = r_next_idx;
          rid_d      = axi.arid;
          rlen_d     = axi.arlen;
          rburst_d   = axi.arburst;
          rbeat_d    = '0;
          rok_d      = r_next_ok;
          rresp_d    = r_next_ok ? RESP_OKAY : RESP_SLVERR;
          rlast_d    = (axi.arlen == 8'd0);
          r_state_d  = R_DATA;
        end
      end
      R_DATA: begin
        r_valid = 1'b1;
        if (axi.rready) begin
          if (rlast_q) begin
            r_state_d = R_IDLE;
          end else begin
            // Prefetch the next beat so the RAM output is ready one cycle later.
            r_next_idx = (rburst_q == BURST_INCR) ? ridx_q + ADDR_WIDTH'(1) : ridx_q;
            r_next_ok  = burst_supported(rburst_q) && (r_next_idx < DEPTH_WORDS);
            ram_re     = r_next_ok;
            ridx_d     = r_next_idx;
            rbeat_d    = rbeat_q + 8'd1;
            rok_d      = r_next_ok;
            rresp_d    = r_next_ok ? RESP_OKAY : RESP_SLVERR;
            rlast_d    = ((rbeat_q + 8'd1) == rlen_q);
          end
        end
      end
    endcase
  end

  assign err_now    = (b_valid && werr_q) || (r_valid && (rresp_q == RESP_SLVERR));
  assign err_sticky = err_sticky_q | err_now;

  always_ff @(posedge clk_wr) begin
    if (rst_wr) begin
      w_state_q    <= W_IDLE;
      wid_q        <= '0;
      widx_q       <= '0;
      wlen_q       <= '0;
      wcnt_q       <= '0;
      wburst_q     <= '0;
      werr_q       <= 1'b0;
      r_state_q    <= R_IDLE;
      rid_q        <= '0;
      ridx_q       <= '0;
      rlen_q       <= '0;
      rbeat_q      <= '0;
      rburst_q     <= '0;
      rresp_q      <= '0;
      rlast_q      <= 1'b0;
      rok_q        <= 1'b0;
      ready_en_q   <= 1'b0;
      err_sticky_q <= 1'b0;
    end else begin
      w_state_q    <= w_state_d;
      wid_q        <= wid_d;
      widx_q       <= widx_d;
      wlen_q       <= wlen_d;
      wcnt_q       <= wcnt_d;
      wburst_q     <= wburst_d;
      werr_q       <= werr_d;
      r_state_q    <= r_state_d;
      rid_q        <= rid_d;
      ridx_q       <= ridx_d;
      rlen_q       <= rlen_d;
      rbeat_q      <= rbeat_d;
      rburst_q     <= rburst_d;
      rresp_q      <= rresp_d;
      rlast_q      <= rlast_d;
      rok_q        <= rok_d;
      ready_en_q   <= 1'b1;
      err_sticky_q <= err_sticky;
    end
  end

  axi_mem_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) u_ram (
    .clk_i   (clk_wr),
    .we_i    (ram_we),
    .waddr_i (widx_q[IDX_WIDTH-1:0]),
    .wdata_i (axi.wdata),
    .wstrb_i (axi.wstrb),
    .re_i    (ram_re),
    .raddr_i (r_next_idx[IDX_WIDTH-1:0]),
    .rdata_o (ram_rdata)
  );

  assign axi.awready = aw_ready;
  assign axi.wready  = w_ready;
  assign axi.bvalid  = b_valid;
  assign axi.bid     = wid_q;
  assign axi.bresp   = (b_valid && werr_q) ? RESP_SLVERR : RESP_OKAY;
  assign axi.arready = ar_ready;
  assign axi.rvalid  = r_valid;
  assign axi.rid     = rid_q;
  assign axi.rdata   = rok_q ? ram_rdata : '0;
  assign axi.rresp   = rresp_q;
  assign axi.rlast   = rlast_q;

endmodule

// File: tb/tb_axi_mem_responder.sv
// Directed bench for axi_mem_responder with default parameters (64-bit, 256 words).
module tb_axi_mem_responder;
  import axi_mem_pkg::*;

  localparam int unsigned DW = 64;
  localparam int unsigned AW = 32;
  localparam int unsigned IW = 4;

  logic clk_wr = 1'b0;
  logic rst_wr;
  logic err_sticky;
  int   checks   = 0;
  int   errors   = 0;
  int   timeouts = 0;

  axi_mem_responder_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ID_WIDTH(IW)) bus ();

  axi_mem_responder #(
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (AW),
    .ID_WIDTH   (IW),
    .DEPTH      (256),
    .BASE_ADDR  (32'h0)
  ) dut (
    .clk_wr     (clk_wr),
    .rst_wr     (rst_wr),
    .axi        (bus.slave),
    .err_sticky (err_sticky)
  );

  always #5 clk_wr = ~clk_wr;

  // Stimulus helpers start and end on a falling edge.
  task automatic send_aw(input logic [IW-1:0] id, input logic [AW-1:0] addr,
                         input logic [7:0] len, input logic [1:0] burst);
    int n = 0;
    bus.awid = id; bus.awaddr = addr; bus.awlen = len; bus.awsize = 3'd3;
    bus.awburst = burst; bus.awvalid = 1'b1;
    while (!bus.awready && n < 20) begin @(negedge clk_wr); n++; end
    if (!bus.awready) timeouts++;
    else begin @(posedge clk_wr); @(negedge clk_wr); end
    bus.awvalid = 1'b0;
  endtask

  task automatic send_w(input logic [DW-1:0] data, input logic [DW/8-1:0] strb, input logic last);
    int n = 0;
    bus.wdata = data; bus.wstrb = strb; bus.wlast = last; bus.wvalid = 1'b1;
    while (!bus.wready && n < 20) begin @(negedge clk_wr); n++; end
    if (!bus.wready) timeouts++;
    else begin @(posedge clk_wr); @(negedge clk_wr); end
    bus.wvalid = 1'b0;
  endtask

  task automatic send_ar(input logic [IW-1:0] id, input logic [AW-1:0] addr,
                         input logic [7:0] len, input logic [1:0] burst);
    int n = 0;
    bus.arid = id; bus.araddr = addr; bus.arlen = len; bus.arsize = 3'd3;
    bus.arburst = burst; bus.arvalid = 1'b1;
    while (!bus.arready && n < 20) begin @(negedge clk_wr); n++; end
    if (!bus.arready) timeouts++;
    else begin @(posedge clk_wr); @(negedge clk_wr); end
    bus.arvalid = 1'b0;
  endtask

  task automatic get_b(output logic [IW-1:0] id, output logic [1:0] resp, output logic sticky);
    int n = 0;
    bus.bready = 1'b1;
    while (!bus.bvalid && n < 20) begin @(negedge clk_wr); n++; end
    if (!bus.bvalid) begin
      timeouts++; id = '1; resp = 2'b11; sticky = 1'bx;
    end else begin
      id = bus.bid; resp = bus.bresp; sticky = err_sticky;
      @(posedge clk_wr); @(negedge clk_wr);
    end
    bus.bready = 1'b0;
  endtask

  // Leaves rready high so consecutive calls can run back to back.
  task automatic read_beat(output logic [DW-1:0] data, output logic [1:0] resp,
                           output logic last, output logic [IW-1:0] id, output int waited);
    waited = 0;
    bus.rready = 1'b1;
    while (!bus.rvalid && waited < 20) begin @(negedge clk_wr); waited++; end
    data = bus.rdata; resp = bus.rresp; last = bus.rlast; id = bus.rid;
    if (bus.rvalid) begin @(posedge clk_wr); @(negedge clk_wr); end
    else timeouts++;
  endtask

  task automatic test_reset;
    rst_wr = 1'b1;
    bus.awvalid = 1'b0; bus.wvalid = 1'b0; bus.bready = 1'b0;
    bus.arvalid = 1'b0; bus.rready = 1'b0;
    bus.awid = '0; bus.awaddr = '0; bus.awlen = '0; bus.awsize = '0; bus.awburst = '0;
    bus.wdata = '0; bus.wstrb = '0; bus.wlast = 1'b0;
    bus.arid = '0; bus.araddr = '0; bus.arlen = '0; bus.arsize = '0; bus.arburst = '0;
    repeat (2) @(negedge clk_wr);
    checks++;
    if ({bus.awready, bus.wready, bus.bvalid, bus.arready, bus.rvalid, bus.rlast, err_sticky}
        !== 7'b0) begin
      errors++;
      $display("FAIL reset_ctrl: got %b expected 0000000", {bus.awready, bus.wready,
               bus.bvalid, bus.arready, bus.rvalid, bus.rlast, err_sticky});
    end
    checks++;
    if ({bus.bresp, bus.rresp, bus.bid, bus.rid} !== 12'b0) begin
      errors++;
      $display("FAIL reset_resp_id: got %h expected 000", {bus.bresp, bus.rresp, bus.bid, bus.rid});
    end
    checks++;
    if (bus.rdata !== 64'b0) begin
      errors++;
      $display("FAIL reset_rdata: got %h expected 0", bus.rdata);
    end
    rst_wr = 1'b0;
    repeat (2) @(negedge clk_wr);
    checks++;
    if ({bus.awready, bus.arready} !== 2'b11) begin
      errors++;
      $display("FAIL idle_ready: got %b expected 11", {bus.awready, bus.arready});
    end
  endtask

  task automatic test_single;
    logic [IW-1:0] id; logic [1:0] resp; logic st, last; logic [DW-1:0] d; int w;
    send_aw(4'h5, 32'h10, 8'd0, BURST_INCR);
    send_w(64'hDEADBEEF_CAFEF00D, 8'hFF, 1'b1);
    checks++;
    if (bus.bvalid !== 1'b1) begin
      errors++;
      $display("FAIL single_bvalid_timing: got %b expected 1", bus.bvalid);
    end
    get_b(id, resp, st);
    checks++;
    if (id !== 4'h5 || resp !== RESP_OKAY) begin
      errors++;
      $display("FAIL single_b: got id %h resp %b expected id 5 resp 00", id, resp);
    end
    send_ar(4'hA, 32'h10, 8'd0, BURST_INCR);
    read_beat(d, resp, last, id, w);
    bus.rready = 1'b0;
    checks++;
    if (d !== 64'hDEADBEEF_CAFEF00D || resp !== RESP_OKAY || last !== 1'b1 || id !== 4'hA
        || w !== 0) begin
      errors++;
      $display("FAIL single_r: got d %h resp %b last %b id %h wait %0d expected d deadbeefcafef00d resp 00 last 1 id a wait 0",
               d, resp, last, id, w);
    end
    checks++;
    if (timeouts !== 0) begin
      errors++;
      $display("FAIL single_handshake: got %0d timeouts expected 0", timeouts);
    end
    timeouts = 0;
  endtask

  task automatic test_incr_burst;
    logic [IW-1:0] id; logic [1:0] resp; logic st, last, sl; logic [DW-1:0] d, sd; int w;
    send_aw(4'h1, 32'h0, 8'd3, BURST_INCR);
    for (int i = 0; i < 4; i++) send_w(64'(i + 1), 8'hFF, i == 3);
    get_b(id, resp, st);
    checks++;
    if (id !== 4'h1 || resp !== RESP_OKAY) begin
      errors++;
      $display("FAIL incr_b: got id %h resp %b expected id 1 resp 00", id, resp);
    end
    send_ar(4'h2, 32'h0, 8'd3, BURST_INCR);
    for (int i = 0; i < 4; i++) begin
      read_beat(d, resp, last, id, w);
      checks++;
      if (d !== 64'(i + 1) || last !== (i == 3) || resp !== RESP_OKAY || id !== 4'h2 || w !== 0)
      begin
        errors++;
        $display("FAIL incr_beat%0d: got d %h last %b resp %b id %h wait %0d expected d %0d last %0d resp 00 id 2 wait 0",
                 i, d, last, resp, id, w, i + 1, i == 3);
      end
    end
    bus.rready = 1'b0;
    send_ar(4'h2, 32'h0, 8'd3, BURST_INCR);
    for (int i = 0; i < 4; i++) begin
      bus.rready = 1'b0;
      sd = bus.rdata; sl = bus.rlast;
      @(negedge clk_wr);
      checks++;
      if (bus.rvalid !== 1'b1 || bus.rdata !== sd || bus.rlast !== sl || sd !== 64'(i + 1)) begin
        errors++;
        $display("FAIL incr_hold%0d: got valid %b d %h last %b expected valid 1 d %0d last %b",
                 i, bus.rvalid, bus.rdata, bus.rlast, i + 1, sl);
      end
      read_beat(d, resp, last, id, w);
      checks++;
      if (d !== 64'(i + 1) || last !== (i == 3)) begin
        errors++;
        $display("FAIL incr_toggle%0d: got d %h last %b expected d %0d last %0d",
                 i, d, last, i + 1, i == 3);
      end
    end
    bus.rready = 1'b0;
    checks++;
    if (timeouts !== 0) begin
      errors++;
      $display("FAIL incr_handshake: got %0d timeouts expected 0", timeouts);
    end
    timeouts = 0;
  endtask

  task automatic test_strobe;
    logic [IW-1:0] id; logic [1:0] resp; logic st, last; logic [DW-1:0] d; int w;
    send_aw(4'h3, 32'h20, 8'd0, BURST_INCR);
    send_w(64'hFFFFFFFF_FFFFFFFF, 8'hFF, 1'b1);
    get_b(id, resp, st);
    send_aw(4'h3, 32'h20, 8'd0, BURST_INCR);
    send_w(64'h0, 8'h0F, 1'b1);
    get_b(id, resp, st);
    send_ar(4'h3, 32'h20, 8'd0, BURST_INCR);
    read_beat(d, resp, last, id, w);
    bus.rready = 1'b0;
    checks++;
    if (d !== 64'hFFFFFFFF_00000000 || resp !== RESP_OKAY) begin
      errors++;
      $display("FAIL strobe: got d %h resp %b expected d ffffffff00000000 resp 00", d, resp);
    end
    checks++;
    if (timeouts !== 0) begin
      errors++;
      $display("FAIL strobe_handshake: got %0d timeouts expected 0", timeouts);
    end
    timeouts = 0;
  endtask

  task automatic test_boundary;
    logic [IW-1:0] id; logic [1:0] resp; logic st, last; logic [DW-1:0] d; int w;
    checks++;
    if (err_sticky !== 1'b0) begin
      errors++;
      $display("FAIL sticky_clear: got %b expected 0", err_sticky);
    end
    send_aw(4'h6, 32'h7F8, 8'd1, BURST_INCR);
    send_w(64'h1111, 8'hFF, 1'b0);
    send_w(64'h2222, 8'hFF, 1'b1);
    get_b(id, resp, st);
    checks++;
    if (id !== 4'h6 || resp !== RESP_SLVERR || st !== 1'b1) begin
      errors++;
      $display("FAIL boundary_b: got id %h resp %b sticky %b expected id 6 resp 10 sticky 1",
               id, resp, st);
    end
    send_ar(4'h7, 32'h7F8, 8'd1, BURST_INCR);
    read_beat(d, resp, last, id, w);
    checks++;
    if (d !== 64'h1111 || resp !== RESP_OKAY || last !== 1'b0) begin
      errors++;
      $display("FAIL boundary_r0: got d %h resp %b last %b expected d 1111 resp 00 last 0",
               d, resp, last);
    end
    read_beat(d, resp, last, id, w);
    checks++;
    if (d !== 64'h0 || resp !== RESP_SLVERR || last !== 1'b1 || w !== 0) begin
      errors++;
      $display("FAIL boundary_r1: got d %h resp %b last %b wait %0d expected d 0 resp 10 last 1 wait 0",
               d, resp, last, w);
    end
    bus.rready = 1'b0;
    send_ar(4'h7, 32'h0, 8'd0, BURST_INCR);
    read_beat(d, resp, last, id, w);
    bus.rready = 1'b0;
    checks++;
    if (d !== 64'h1 || err_sticky !== 1'b1) begin
      errors++;
      $display("FAIL boundary_nowrap: got word0 %h sticky %b expected word0 1 sticky 1",
               d, err_sticky);
    end
    checks++;
    if (timeouts !== 0) begin
      errors++;
      $display("FAIL boundary_handshake: got %0d timeouts expected 0", timeouts);
    end
    timeouts = 0;
  endtask

  task automatic test_wrap;
    logic [IW-1:0] id; logic [1:0] resp; logic st, last; logic [DW-1:0] d; int w;
    send_aw(4'hB, 32'h0, 8'd3, BURST_WRAP);
    for (int i = 0; i < 4; i++) send_w(64'hAA00 + 64'(i), 8'hFF, i == 3);
    get_b(id, resp, st);
    checks++;
    if (id !== 4'hB || resp !== RESP_SLVERR) begin
      errors++;
      $display("FAIL wrap_b: got id %h resp %b expected id b resp 10", id, resp);
    end
    send_ar(4'hC, 32'h0, 8'd3, BURST_INCR);
    for (int i = 0; i < 4; i++) begin
      read_beat(d, resp, last, id, w);
      checks++;
      if (d !== 64'(i + 1) || resp !== RESP_OKAY) begin
        errors++;
        $display("FAIL wrap_unchanged%0d: got d %h resp %b expected d %0d resp 00",
                 i, d, resp, i + 1);
      end
    end
    bus.rready = 1'b0;
    send_ar(4'hC, 32'h8, 8'd1, BURST_WRAP);
    for (int i = 0; i < 2; i++) begin
      read_beat(d, resp, last, id, w);
      checks++;
      if (d !== 64'h0 || resp !== RESP_SLVERR || last !== (i == 1)) begin
        errors++;
        $display("FAIL wrap_read%0d: got d %h resp %b last %b expected d 0 resp 10 last %0d",
                 i, d, resp, last, i == 1);
      end
    end
    bus.rready = 1'b0;
    checks++;
    if (timeouts !== 0) begin
      errors++;
      $display("FAIL wrap_handshake: got %0d timeouts expected 0", timeouts);
    end
    timeouts = 0;
  endtask

  task automatic test_reset_mid_burst;
    logic [IW-1:0] id; logic [1:0] resp; logic st, last; logic [DW-1:0] d; int w;
    send_aw(4'h8, 32'h100, 8'd3, BURST_INCR);
    send_w(64'h51, 8'hFF, 1'b0);
    send_w(64'h52, 8'hFF, 1'b0);
    rst_wr = 1'b1;
    @(negedge clk_wr);
    checks++;
    if ({bus.awready, bus.wready, bus.bvalid, bus.arready, bus.rvalid, err_sticky} !== 6'b0)
    begin
      errors++;
      $display("FAIL midreset_ctrl: got %b expected 000000", {bus.awready, bus.wready,
               bus.bvalid, bus.arready, bus.rvalid, err_sticky});
    end
    rst_wr = 1'b0;
    send_aw(4'h9, 32'h200, 8'd0, BURST_INCR);
    send_w(64'h77, 8'hFF, 1'b1);
    get_b(id, resp, st);
    checks++;
    if (id !== 4'h9 || resp !== RESP_OKAY) begin
      errors++;
      $display("FAIL midreset_b: got id %h resp %b expected id 9 resp 00", id, resp);
    end
    send_ar(4'hD, 32'h100, 8'd1, BURST_INCR);
    for (int i = 0; i < 2; i++) begin
      read_beat(d, resp, last, id, w);
      checks++;
      if (d !== 64'h51 + 64'(i) || resp !== RESP_OKAY || last !== (i == 1)) begin
        errors++;
        $display("FAIL midreset_r%0d: got d %h resp %b last %b expected d %h resp 00 last %0d",
                 i, d, resp, last, 64'h51 + 64'(i), i == 1);
      end
    end
    bus.rready = 1'b0;
    checks++;
    if (timeouts !== 0) begin
      errors++;
      $display("FAIL midreset_handshake: got %0d timeouts expected 0", timeouts);
    end
    timeouts = 0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_incr_burst();
    test_strobe();
    test_boundary();
    test_wrap();
    test_reset_mid_burst();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/axi_mem_responder.md
Name: axi_mem_responder

Overview:
- AXI4 memory-mapped slave endpoint that sits directly downstream of the slave-side AIB AXI bridge.
- Consumes AW/W/AR requests presented on the bridge's user-side AXI master port and returns B/R responses from an internal word-addressed RAM.
- Serves as the far-end target for end-to-end bring-up and regression of the die-to-die AXI link.
- One outstanding write and one outstanding read, handled by independent write and read FSMs.

Parameters:
- DATA_WIDTH, 64, AXI data width in bits; power of two, ≥ 32.
- ADDR_WIDTH, 32, AXI address width.
- ID_WIDTH, 4, AXI ID width; IDs are echoed on B/R.
- DEPTH, 256, RAM depth in DATA_WIDTH words; power of two.
- BASE_ADDR, 32'h0, byte address of RAM word 0.

Ports:
- clk_wr  in  1  Block clock; the same clock as the bridge's clk_wr.
- rst_wr  in  1  Reset: synchronous, active-high.
- awid/awaddr/awlen/awsize/awburst  in  ID_WIDTH/ADDR_WIDTH/8/3/2  Write address channel.
- awvalid in 1; awready out 1.
- wdata/wstrb/wlast  in  DATA_WIDTH/DATA_WIDTH/8/1  Write data channel.
- wvalid in 1; wready out 1.
- bid/bresp  out  ID_WIDTH/2  Write response.
- bvalid out 1; bready in 1.
- arid/araddr/arlen/arsize/arburst  in  ID_WIDTH/ADDR_WIDTH/8/3/2  Read address channel.
- arvalid in 1; arready out 1.
- rid/rdata/rresp/rlast  out  ID_WIDTH/DATA_WIDTH/2/1  Read data channel.
- rvalid out 1; rready in 1.
- err_sticky  out  1  Set on any SLVERR response; cleared only by reset.

Behaviour:
- Reset (rst_wr=1 at a clk_wr edge):
  - Both FSMs return to IDLE; all valid and ready outputs go to 0.
  - bresp, rresp, bid, rid, rdata, rlast and err_sticky go to 0.
  - RAM contents are not reset.
- Reset mid-burst: the transaction is abandoned. No B or R is issued for it, and RAM writes for beats already accepted remain.
- Word index is (addr - BASE_ADDR) >> log2(DATA_WIDTH/8). A beat is in range when 0 ≤ offset < DEPTH*DATA_WIDTH/8.
- awsize/arsize are ignored; every beat is full width.
- wstrb gives per-byte write enables.
- Burst types:
  - FIXED (2'b00): index is constant across the burst.
  - INCR (2'b01): index +1 per beat.
  - WRAP (2'b10) and reserved (2'b11): unsupported. All beats are still consumed or produced, no RAM access occurs, and the response is SLVERR.
- Write FSM:
  - W_IDLE: awready=1. On the AW handshake, latch id, index, len and burst; clear the beat counter and the error flag; go to W_DATA.
  - W_DATA: wready=1. Each W handshake writes the RAM if in range, otherwise sets the error flag. The beat counter increments. The beat where counter==awlen goes to W_RESP.
  - W_RESP: bvalid=1, bid=latched id, bresp = error ? 2'b10 : 2'b00. Hold stable until bready; then go to W_IDLE.
  - bvalid rises the cycle after the last W handshake.
  - awready is 0 outside W_IDLE.
- Read FSM:
  - R_IDLE: arready=1. On the AR handshake, latch fields and issue the RAM read; go to R_DATA.
  - R_DATA: rvalid=1 starting the cycle after the AR handshake (1-cycle latency).
    - rdata = RAM word, or 0 if the beat is out of range or the burst is unsupported.
    - rresp is per beat.
    - rlast=1 when beat==arlen.
    - rdata/rresp/rlast hold stable while rready=0.
    - On a handshake, prefetch the next word so that back-to-back beats run at 1 per cycle. After the rlast handshake, go to R_IDLE.
- An INCR burst crossing the RAM end errors only the out-of-range beats. The index never wraps to 0.
- Simultaneous read and write to the same word in one cycle: the read returns the old data (read-before-write).
- err_sticky is set the cycle a SLVERR B or R beat is presented.

Optional Feature:
- AXI_MEM_RESP_LAST_CHECK_EN defined:
  - W_DATA compares wlast against (counter==awlen) on every beat.
  - On a mismatch, set the error flag (bresp=SLVERR) and err_sticky.
  - Early wlast ends the burst immediately.
  - A missing wlast still ends the burst at counter==awlen.
- Undefined: wlast is ignored, and the burst length comes solely from awlen.

Decomposition:
- Package axi_mem_pkg:
  - RESP_OKAY=2'b00 and RESP_SLVERR=2'b10.
  - BURST_FIXED/INCR/WRAP.
  - Write-state enum (W_IDLE, W_DATA, W_RESP) and read-state enum (R_IDLE, R_DATA).
- Sub-module axi_mem_ram: 1W1R synchronous RAM with byte enables and read-before-write.

Test Plan:
- Single write then read: AW addr 0x10, len 0, INCR; W 0xDEADBEEF_CAFEF00D, strb 0xFF.
  - Expect bresp OKAY with bid echoed.
  - AR addr 0x10 returns the same data with rlast=1; first rvalid arrives 1 cycle after AR.
- INCR burst: write len 3 at 0x0 with data 1..4, then read len 3.
  - Expect 4 beats 1,2,3,4 at 1 beat/cycle with rready=1, rlast on beat 3 only.
  - With rready toggling, outputs hold stable.
- Byte strobe: write 0xFF..FF, then write 0x0 with strb 0x0F.
  - Read returns 0xFFFFFFFF_00000000.
- Boundary: INCR len 1 starting at the last word (0x7F8 for the default parameters).
  - Beat 0 is OKAY; beat 1 has rresp SLVERR and rdata 0.
  - The same write gets bresp SLVERR; err_sticky=1.
- WRAP burst len 3: all 4 W beats are accepted, RAM is unchanged, bresp=SLVERR.
- Reset mid-burst: assert rst_wr after 2 of 4 W beats.
  - All valid/ready outputs are 0 the next cycle.
  - A new write after reset completes with OKAY.
  - Beats written before the reset read back.
